// File: rtl/obc_dft_pkg.sv
// obc_dft_pkg
//   Shared definitions for the offset-binary-coded (OBC) 16-point DFT stages:
//   point count, default datapath widths, the plane-sequencer FSM state
//   encoding and the accumulator width check every OBC stage applies.
package obc_dft_pkg;

    localparam int OBC_NPOINT = 16;

    localparam int OBC_DATA_W = 16;
    localparam int OBC_ROM_W  = 32;
    localparam int OBC_ACC_W  = 48;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLANE  = 2'd1,
        ST_FINISH = 2'd2,
        ST_OUT    = 2'd3
    } obc_state_t;

    // The accumulator must hold a ROM word shifted by up to DATA_W-1 places
    // plus the sign headroom, otherwise the weighted sum silently loses bits.
    function automatic bit obc_acc_width_ok(int acc_w, int rom_w, int data_w);
        return acc_w >= rom_w + data_w;
    endfunction

endpackage

// File: rtl/obc_plane_mux.sv
// obc_plane_mux
//   Combinational bit-plane extraction: bit k of x is bit `plane` of sample k.
//   Output is forced to zero when en is low.
// Ports
//   samples  in  OBC_NPOINT*DATA_W  latched samples, sample k at [k*DATA_W +: DATA_W]
//   plane    in  $clog2(DATA_W)     bit index to extract
//   en       in  1                  plane presentation active
//   x        out OBC_NPOINT         selected bit-plane
module obc_plane_mux
    import obc_dft_pkg::*;
#(
    parameter int DATA_W = OBC_DATA_W,
    parameter int J_W    = $clog2(OBC_DATA_W)
) (
    input  logic [OBC_NPOINT*DATA_W-1:0] samples,
    input  logic [J_W-1:0]               plane,
    input  logic                         en,
    output logic [OBC_NPOINT-1:0]        x
);

    logic [DATA_W-1:0] sample;

    always_comb begin
        x      = '0;
        sample = '0;
        if (en) begin
            for (int k = 0; k < OBC_NPOINT; k++) begin
                sample = samples[k*DATA_W +: DATA_W];
                x[k]   = sample[plane];
            end
        end
    end

endmodule

// File: rtl/obc_plane_sequencer_acc.sv
// obc_plane_sequencer_acc
//   Bit-serial control and accumulation stage of the OBC 16-point DFT.
//   Accepts a block of 16 signed samples, presents one bit-plane per cycle
//   (x_o plus inversion flag m_o) to the combinational OBC ROM stage, weights
//   and accumulates the returned partial sums, adds the OBC offset, halves the
//   result and hands it out on a valid/ready port.
//   Build option: define OBC_ROUND_EN for round-half-up on the final halving;
//   undefined gives floor (arithmetic shift). Latency and ports are identical.
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  sample block handshake, in_data 16*DATA_W, offset_i ROM_W
//   x_o, m_o        bit-plane and inversion flag to the ROM stage
//   romout_i        ROM partial sum for the current x_o/m_o (same cycle)
//   out_valid/ready result handshake, y_o ACC_W signed result
//   state_dbg       current FSM state (obc_state_t encoding)
module obc_plane_sequencer_acc
    import obc_dft_pkg::*;
#(
    parameter int DATA_W = OBC_DATA_W,
    parameter int ROM_W  = OBC_ROM_W,
    parameter int ACC_W  = OBC_ACC_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OBC_NPOINT*DATA_W-1:0] in_data,
    input  logic [ROM_W-1:0]             offset_i,
    output logic [OBC_NPOINT-1:0]        x_o,
    output logic                         m_o,
    input  logic [ROM_W-1:0]             romout_i,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             y_o,
    output logic [1:0]                   state_dbg
);

    localparam int J_W = $clog2(DATA_W);

    if (!obc_acc_width_ok(ACC_W, ROM_W, DATA_W)) begin : g_width_check
        $error("obc_plane_sequencer_acc: ACC_W must be >= ROM_W + DATA_W");
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high. in_ready is high only in IDLE; out_valid is high only in
    // OUT and y_o is held constant until the transfer completes.

    obc_state_t                  state, state_next;
    logic [OBC_NPOINT*DATA_W-1:0] samples;
    logic [ROM_W-1:0]            offset_q;
    logic [ACC_W-1:0]            acc;
    logic [J_W-1:0]              j;
    logic [ACC_W-1:0]            y;

    logic                        last_plane;
    logic [ACC_W-1:0]            rom_ext;
    logic [ACC_W-1:0]            off_ext;
    logic [ACC_W-1:0]            plane_term;
    logic [ACC_W-1:0]            round_inc;
    logic signed [ACC_W-1:0]     fin_sum;
    logic [ACC_W-1:0]            y_next;

    assign last_plane = (j == J_W'(DATA_W - 1));

    // The MSB plane is added like every other plane: the ROM stage already
    // returns the negated partial sum when m_o is high.
    assign rom_ext    = {{(ACC_W-ROM_W){romout_i[ROM_W-1]}}, romout_i};
    assign off_ext    = {{(ACC_W-ROM_W){offset_q[ROM_W-1]}}, offset_q};
    assign plane_term = rom_ext << j;

`ifdef OBC_ROUND_EN
    assign round_inc = ACC_W'(1);
`else
    assign round_inc = '0;
`endif

    // OBC output is half of (weighted sum + offset); sum wraps in ACC_W bits.
    assign fin_sum = acc + off_ext + round_inc;
    assign y_next  = fin_sum >>> 1;

    obc_plane_mux #(
        .DATA_W (DATA_W),
        .J_W    (J_W)
    ) u_plane_mux (
        .samples (samples),
        .plane   (j),
        .en      (state == ST_PLANE),
        .x       (x_o)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        m_o        = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_PLANE;
            end
            ST_PLANE: begin
                m_o = last_plane;
                if (last_plane) state_next = ST_FINISH;
            end
            ST_FINISH: begin
                state_next = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            samples  <= '0;
            offset_q <= '0;
            acc      <= '0;
            j        <= '0;
            y        <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        samples  <= in_data;
                        offset_q <= offset_i;
                        acc      <= '0;
                        j        <= '0;
                    end
                end
                ST_PLANE: begin
                    acc <= acc + plane_term;
                    j   <= j + J_W'(1);
                end
                ST_FINISH: begin
                    y <= y_next;
                end
                default: ;
            endcase
        end
    end

    assign y_o       = y;
    assign state_dbg = state;

endmodule

// File: tb/tb_obc_plane_sequencer_acc.sv
// tb_obc_plane_sequencer_acc
//   Self-checking bench for obc_plane_sequencer_acc. A bench ROM replaces the
//   OBC ROM stage: either a per-plane table or a hash of (x_o, m_o).
//   Expected results are pushed at accept time and popped on each output
//   handshake. Honours OBC_ROUND_EN for the expected values.
module tb_obc_plane_sequencer_acc;
  import obc_dft_pkg::*;

  localparam int NPT    = 16;
  localparam int DATA_W = 16;
  localparam int ROM_W  = 32;
  localparam int ACC_W  = 48;

  // ---------------- clock / reset / signals ----------------
  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [NPT*DATA_W-1:0] in_data;
  logic [ROM_W-1:0]      offset_i;
  logic [NPT-1:0]        x_o;
  logic                  m_o;
  logic [ROM_W-1:0]      romout_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_W-1:0]      y_o;
  logic [1:0]            state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  obc_plane_sequencer_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .offset_i  (offset_i),
    .x_o       (x_o),
    .m_o       (m_o),
    .romout_i  (romout_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_o       (y_o),
    .state_dbg (state_dbg)
  );

  // ---------------- bench ROM model ----------------
  int               tests_run    = 0;
  int               tests_failed = 0;
  logic [ACC_W-1:0] exp_q[$];
  logic             use_tab;
  logic [ROM_W-1:0] rom_tab[NPT];
  int               plane_idx;
  int               accept_cyc;

  function automatic logic [ROM_W-1:0] rom_fn(logic [NPT-1:0] x, logic m);
    logic [ROM_W-1:0] p;
    p = {16'h0, x} * 32'h9E3779B1;
    return m ? ~p : p;
  endfunction

  always_comb romout_i = use_tab ? rom_tab[plane_idx[3:0]] : rom_fn(x_o, m_o);

  function automatic logic [NPT-1:0] plane_bits(logic [NPT*DATA_W-1:0] d, int j);
    logic [NPT-1:0] r;
    for (int k = 0; k < NPT; k++) r[k] = d[k*DATA_W + j];
    return r;
  endfunction

  function automatic logic [ACC_W-1:0] model_y(logic [NPT*DATA_W-1:0] d, logic [ROM_W-1:0] off);
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic [ROM_W-1:0]        r;
    acc = '0;
    for (int j = 0; j < DATA_W; j++) begin
      r   = use_tab ? rom_tab[j] : rom_fn(plane_bits(d, j), j == DATA_W - 1);
      acc = acc + ({{(ACC_W-ROM_W){r[ROM_W-1]}}, r} << j);
    end
    sum = acc + {{(ACC_W-ROM_W){off[ROM_W-1]}}, off};
`ifdef OBC_ROUND_EN
    sum = sum + 48'sd1;
`endif
    return sum >>> 1;
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [ACC_W-1:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_output: y_o=%0d, required no output", $signed(y_o));
      end else begin
        mon_exp = exp_q.pop_front();
        if (y_o !== mon_exp) begin
          tests_failed++;
          $display("FAIL result: y_o=%0d, required %0d", $signed(y_o), $signed(mon_exp));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1. Returns at posedge+#1 in the FINISH cycle.
  task automatic drive_block(input logic [NPT*DATA_W-1:0] d, input logic [ROM_W-1:0] off,
                             input bit hold, input bit given, input logic [ACC_W-1:0] given_y);
    int n;
    n        = 0;
    in_data  = d;
    offset_i = off;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (!in_ready) begin
      tests_failed++;
      $display("FAIL accept_timeout: in_ready=%0b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    accept_cyc = cyc;
    exp_q.push_back(given ? given_y : model_y(d, off));
    in_valid = hold;
    for (int j = 0; j < DATA_W; j++) begin
      plane_idx = j;
      @(negedge clk);
      tests_run++;
      if (x_o !== plane_bits(d, j) || m_o !== 1'(j == DATA_W - 1)) begin
        tests_failed++;
        $display("FAIL plane%0d: x_o=%h m_o=%0b, required x_o=%h m_o=%0b",
                 j, x_o, m_o, plane_bits(d, j), j == DATA_W - 1);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: pending=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [NPT*DATA_W-1:0] rand_block();
    logic [NPT*DATA_W-1:0] d;
    for (int i = 0; i < NPT*DATA_W/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y_o !== '0 || x_o !== '0 || m_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: in_ready=%0b out_valid=%0b y_o=%h x_o=%h m_o=%0b, required 1 0 0 0 0",
               in_ready, out_valid, y_o, x_o, m_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_plane_presentation();
    logic [NPT*DATA_W-1:0] d;
    use_tab = 1'b1;
    for (int j = 0; j < NPT; j++) rom_tab[j] = '0;
    for (int k = 0; k < NPT; k++) d[k*DATA_W +: DATA_W] = 16'h8001;
    drive_block(d, 32'd0, 1'b0, 1'b1, 48'd0);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || x_o !== 16'h0000 || m_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL finish_cycle: out_valid=%0b x_o=%h m_o=%0b, required 0 0000 0", out_valid, x_o, m_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || y_o !== 48'd0 || cyc - accept_cyc != 17) begin
      tests_failed++;
      $display("FAIL out_cycle18: out_valid=%0b y_o=%0d cycle=%0d, required 1 0 18",
               out_valid, $signed(y_o), cyc - accept_cyc + 1);
    end
    wait_drain();
  endtask

  task automatic test_positive_weighting();
    use_tab = 1'b1;
    for (int j = 0; j < NPT; j++) rom_tab[j] = 32'(j + 1);
`ifdef OBC_ROUND_EN
    drive_block(rand_block(), 32'd0, 1'b0, 1'b1, 48'd491521);
`else
    drive_block(rand_block(), 32'd0, 1'b0, 1'b1, 48'd491520);
`endif
    wait_drain();
  endtask

  task automatic test_offset_negative();
    use_tab = 1'b1;
    for (int j = 0; j < NPT; j++) rom_tab[j] = 32'hFFFF_FFFF;
`ifdef OBC_ROUND_EN
    drive_block(rand_block(), 32'd0, 1'b0, 1'b1, -48'sd32767);
`else
    drive_block(rand_block(), 32'd0, 1'b0, 1'b1, -48'sd32768);
`endif
    wait_drain();
    // (-65535 + 1) >>> 1 and (-65535 + 1 + 1) >>> 1 both floor to -32767.
    drive_block(rand_block(), 32'd1, 1'b0, 1'b1, -48'sd32767);
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [ACC_W-1:0]      held;
    logic [NPT*DATA_W-1:0] d_next;
    int                    n;
    int                    hs_cyc;
    use_tab   = 1'b0;
    out_ready = 1'b0;
    d_next    = rand_block();
    drive_block(rand_block(), $urandom, 1'b0, 1'b0, '0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    held = y_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = (i % 2 == 0);
      in_data  = d_next;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || y_o !== held || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall%0d: out_valid=%0b y_o=%h in_ready=%0b, required 1 %h 0",
                 i, out_valid, y_o, in_ready, held);
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    hs_cyc    = cyc;
    drive_block(d_next, $urandom, 1'b0, 1'b0, '0);
    tests_run++;
    if (accept_cyc != hs_cyc + 2) begin
      tests_failed++;
      $display("FAIL accept_after_handshake: delay=%0d, required 2", accept_cyc - hs_cyc);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    logic [NPT*DATA_W-1:0] d;
    use_tab  = 1'b0;
    d        = rand_block();
    in_data  = d;
    offset_i = $urandom;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    tests_run++;
    if (x_o !== plane_bits(d, 7)) begin
      tests_failed++;
      $display("FAIL pre_reset_plane7: x_o=%h, required %h", x_o, plane_bits(d, 7));
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y_o !== '0 || x_o !== '0 || m_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: in_ready=%0b out_valid=%0b y_o=%h x_o=%h m_o=%0b, required 1 0 0 0 0",
               in_ready, out_valid, y_o, x_o, m_o);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || x_o !== '0 || m_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: in_ready=%0b out_valid=%0b x_o=%h m_o=%0b, required 1 0 0 0",
               in_ready, out_valid, x_o, m_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_block(rand_block(), $urandom, 1'b0, 1'b0, '0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int first_cyc;
    use_tab = 1'b0;
    drive_block(rand_block(), $urandom, 1'b1, 1'b0, '0);
    first_cyc = accept_cyc;
    drive_block(rand_block(), $urandom, 1'b0, 1'b0, '0);
    tests_run++;
    if (accept_cyc - first_cyc != 19) begin
      tests_failed++;
      $display("FAIL accept_spacing: gap=%0d, required 19", accept_cyc - first_cyc);
    end
    wait_drain();
  endtask

  task automatic test_random();
    use_tab = 1'b0;
    for (int b = 0; b < 4; b++)
      drive_block(rand_block(), $urandom, b < 3, 1'b0, '0);
    wait_drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    offset_i  = '0;
    out_ready = 1'b1;
    use_tab   = 1'b1;
    plane_idx = 0;
    for (int j = 0; j < NPT; j++) rom_tab[j] = '0;

    test_reset();
    test_plane_presentation();
    test_positive_weighting();
    test_offset_negative();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL leftover_expected: pending=%0d, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
